// File: rtl/req_encoder_q.sv
// req_encoder_q: captures rising edges on four asynchronous request lines,
// holds them as pending, and serves one 2-bit code at a time over valid/ready.
// Optional feature: define REQ_ENC_RR_EN for round-robin selection instead of
// fixed highest-index priority.
module req_encoder_q #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [1:0] out_code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] pending,
   output logic [3:0] overrun,
   input  logic       ovr_clr
);

   localparam int unsigned N_REQ = 4;

   logic [N_REQ-1:0]   sync_q [SYNC_STAGES];
   logic [N_REQ-1:0]   hist_q;
   logic [SYNC_STAGES:0] fill_q;
   logic [N_REQ-1:0]   rise;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   pend_nxt;
   logic [N_REQ-1:0]   ovr_set;
   logic [1:0]         sel;
   logic               load;

   // Synchroniser chain, history flop, and a fill marker that masks the
   // spurious edge of a line already high when reset releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         sync_q[0] <= req;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         hist_q <= sync_q[SYNC_STAGES-1];
         fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q & {N_REQ{fill_q[SYNC_STAGES]}};

`ifdef REQ_ENC_RR_EN
   logic [1:0] last_q;
   logic [1:0] idx;
   logic       found;

   // Round-robin pointer: remembers the most recently granted index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_q <= 2'b11;
      else if (load) last_q <= sel;
   end

   // Search from last+1 upward (mod 4); first pending index wins.
   always_comb begin
      sel   = 2'b00;
      idx   = 2'b00;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = 2'(last_q + 2'(k));
         if (!found && pending[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end
`else
   // Fixed priority: highest pending index wins.
   always_comb begin
      sel = 2'b00;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pending[i]) sel = 2'(i);
      end
   end
`endif

   // Load decision, grant vector and next pending/overrun terms.
   always_comb begin
      load  = (!out_valid || out_ready) && (|pending);
      grant = '0;
      if (load) grant[sel] = 1'b1;
      ovr_set  = rise & pending & ~grant;
      pend_nxt = (pending & ~grant) | rise;
   end

   // Pending and sticky overrun flags; a new set beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= pend_nxt;
         overrun <= ovr_set | (ovr_clr ? '0 : overrun);
      end
   end

   // Output register: load on free slot, drop valid on consume with nothing pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_code  <= 2'b00;
         out_valid <= 1'b0;
      end else if (load) begin
         out_code  <= sel;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_req_encoder_q.sv
// Bench for req_encoder_q: reference model plus directed scenarios.
module tb_req_encoder_q;

   localparam int unsigned S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [1:0] out_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] pending;
   logic [3:0] overrun;
   logic       ovr_clr;

   int checks = 0;
   int errors = 0;

   req_encoder_q #(.SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .out_code(out_code),
      .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
      .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model state
   logic [3:0] m_pend, m_ovr;
   logic [1:0] m_code, m_last;
   logic       m_valid;
   logic [3:0] samples[$];

   function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] last);
      logic [1:0] r;
      r = 2'b00;
`ifdef REQ_ENC_RR_EN
      for (int k = 4; k >= 1; k--) begin
         if (p[(int'(last) + k) % 4]) r = 2'((int'(last) + k) % 4);
      end
`else
      for (int i = 0; i < 4; i++) if (p[i]) r = 2'(i);
`endif
      return r;
   endfunction

   // Model: an edge is two consecutive post-reset samples 0 then 1, seen S edges late.
   always @(posedge clk or negedge rst_n) begin : model
      logic [3:0] r_v, g_v;
      logic [1:0] s_v;
      logic       ld_v;
      if (!rst_n) begin
         m_pend  <= 4'h0;
         m_ovr   <= 4'h0;
         m_code  <= 2'b00;
         m_valid <= 1'b0;
         m_last  <= 2'b11;
         samples.delete();
      end else begin
         r_v = 4'h0;
         if (samples.size() >= S + 1) r_v = samples[S-1] & ~samples[S];
         ld_v = (!m_valid || out_ready) && (m_pend != 4'h0);
         g_v  = 4'h0;
         s_v  = pick(m_pend, m_last);
         if (ld_v) begin
            g_v[s_v] = 1'b1;
            m_code  <= s_v;
            m_valid <= 1'b1;
            m_last  <= s_v;
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
         m_ovr  <= (ovr_clr ? 4'h0 : m_ovr) | (r_v & m_pend & ~g_v);
         m_pend <= (m_pend & ~g_v) | r_v;
         samples.push_front(req);
         if (samples.size() > S + 1) void'(samples.pop_back());
      end
   end

   // Per-cycle comparison against the model.
   always begin
      @(posedge clk);
      #1;
      chk("cyc_valid",   8'(out_valid), 8'(m_valid));
      chk("cyc_code",    8'(out_code),  8'(m_code));
      chk("cyc_pending", 8'(pending),   8'(m_pend));
      chk("cyc_overrun", 8'(overrun),   8'(m_ovr));
   end

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   logic [1:0] exp_sim [3];

   initial begin
`ifdef REQ_ENC_RR_EN
      exp_sim[0] = 2'b00; exp_sim[1] = 2'b01; exp_sim[2] = 2'b11;
`else
      exp_sim[0] = 2'b11; exp_sim[1] = 2'b01; exp_sim[2] = 2'b00;
`endif
      rst_n = 1'b1; req = 4'h0; out_ready = 1'b0; ovr_clr = 1'b0;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_valid",   8'(out_valid), 8'h0);
      chk("rst_code",    8'(out_code),  8'h0);
      chk("rst_pending", 8'(pending),   8'h0);
      chk("rst_overrun", 8'(overrun),   8'h0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Single request
      out_ready = 1'b1;
      req = 4'b0100;
      repeat (3) tick();
      chk("single_pend",  8'(pending),   8'h4);
      chk("single_vlo",   8'(out_valid), 8'h0);
      tick();
      chk("single_valid", 8'(out_valid), 8'h1);
      chk("single_code",  8'(out_code),  8'h2);
      chk("single_clr",   8'(pending),   8'h0);
      tick();
      chk("single_drop",  8'(out_valid), 8'h0);
      req = 4'h0;
      repeat (3) tick();

      // Simultaneous requests
      do_reset();
      out_ready = 1'b1;
      req = 4'b1011;
      repeat (4) tick();
      for (int j = 0; j < 3; j++) begin
         chk("sim_valid", 8'(out_valid), 8'h1);
         chk("sim_code",  8'(out_code),  8'(exp_sim[j]));
         tick();
      end
      chk("sim_drop", 8'(out_valid), 8'h0);
      req = 4'h0;
      repeat (3) tick();

      // Backpressure
      out_ready = 1'b0;
      req = 4'b0001;
      tick();
      req = 4'b0011;
      repeat (3) tick();
      chk("bp_valid", 8'(out_valid), 8'h1);
      chk("bp_code",  8'(out_code),  8'h0);
      chk("bp_pend",  8'(pending),   8'h2);
      tick();
      chk("bp_hold_code", 8'(out_code), 8'h0);
      chk("bp_hold_pend", 8'(pending),  8'h2);
      out_ready = 1'b1;
      tick();
      chk("bp_next_code",  8'(out_code),  8'h1);
      chk("bp_next_valid", 8'(out_valid), 8'h1);
      tick();
      chk("bp_drop", 8'(out_valid), 8'h0);
      req = 4'h0;
      repeat (3) tick();

      // Overrun: occupy the output register, then pulse line 2 twice
      out_ready = 1'b0;
      req = 4'b0001; repeat (2) tick();
      req = 4'h0;    repeat (3) tick();
      req = 4'b0100; repeat (2) tick();
      req = 4'h0;    repeat (2) tick();
      req = 4'b0100; repeat (2) tick();
      req = 4'h0;    repeat (4) tick();
      chk("ovr_flag", 8'(overrun),  8'h4);
      chk("ovr_pend", 8'(pending),  8'h4);
      chk("ovr_code", 8'(out_code), 8'h0);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clear",     8'(overrun), 8'h0);
      chk("ovr_pend_kept", 8'(pending), 8'h4);

      // Reset mid-operation
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      req = 4'b0001;
      repeat (4) tick();
      req = 4'b1011;
      repeat (4) tick();
      chk("mid_valid", 8'(out_valid), 8'h1);
      chk("mid_pend",  8'(pending),   8'ha);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid",   8'(out_valid), 8'h0);
      chk("async_code",    8'(out_code),  8'h0);
      chk("async_pending", 8'(pending),   8'h0);
      chk("async_overrun", 8'(overrun),   8'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("post_rst_valid", 8'(out_valid), 8'h0);
         chk("post_rst_pend",  8'(pending),   8'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/req_encoder_q.md
# req_encoder_q

Request-capture and encoding stage that sits directly upstream of the 4-to-2 encoder datapath. It synchronises four asynchronous request lines and detects their rising edges. It holds each request as pending until served, and emits one 2-bit request code at a time over a valid/ready handshake. Unlike the purely combinational encoder, it never loses a request when several lines fire together and flags any request that arrives while the same line is still pending.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per request line; legal values 2 and 3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: raw asynchronous request lines; bit i means request i.
- `out_code` output 2: encoded index of the served request.
- `out_valid` output 1: `out_code` holds an unconsumed request.
- `out_ready` input 1: the consumer accepts `out_code` on an edge where `out_valid && out_ready`.
- `pending` output 4: captured requests not yet loaded into the output register.
- `overrun` output 4: sticky per-line flag; a second edge arrived while the line was still pending.
- `ovr_clr` input 1: synchronous clear of `overrun`.

## Operation
**Synchronisation and edge detection**
- Each `req[i]` passes through a `SYNC_STAGES`-flop chain, followed by one history flop.
- `rise[i]` is defined as sync_out & ~history. It is combinational and lasts one cycle.

**Pending capture**
- When `rise[i]` is high, `pending[i]` is set on the next edge.
- `pending[i]` is cleared on the edge where line i is granted into the output register.
- If `rise[i]` and the grant of line i occur on the same edge, the set wins. `pending[i]` stays 1 and no overrun is flagged.

**Overrun**
- `overrun[i]` is set when `rise[i]` occurs while `pending[i]` is 1 and line i is not being granted that edge.
- `ovr_clr` clears all `overrun` bits on an edge. A set on the same edge wins over the clear.

**Output register load**
- Load condition: (!`out_valid` || `out_ready`) && (|`pending`).
- On a load, `out_code` takes the selected index, `out_valid` goes to 1, and the selected pending bit clears.
- If `out_valid && out_ready` and no bit is pending, `out_valid` goes to 0 and `out_code` holds its value.
- While `out_valid && !out_ready`, `out_code` and `out_valid` are held stable.

**Selection**
- Fixed priority: the highest pending index wins (3 > 2 > 1 > 0).
- This matches the encoder convention, e.g. 4'b1000 encodes to 2'b11.

**Reset**
- Asynchronous reset clears the synchronisers, history, `pending`, `overrun`, `out_valid` (0) and `out_code` (2'b00), and the round-robin pointer.
- A transfer in flight at reset is dropped.
- After release, a `req` line that is already high does not produce an edge, because the history flop and the synchroniser fill together.

## Timing
- Reset values: `out_valid`=0, `out_code`=2'b00, `pending`=4'b0000, `overrun`=4'b0000.
- Latency: `req[i]` rises and is stable before edge N. `pending[i]` goes to 1 after edge N+`SYNC_STAGES`. `out_valid` goes to 1 after edge N+`SYNC_STAGES`+1, provided the output register is free.
- Throughput: one code per cycle while `out_ready`=1 and requests are pending; there are no bubbles between back-to-back grants.
- Minimum request pulse: `req` must be high for at least 2 clock periods to be captured reliably.
- A pulse shorter than one period may be missed. Behaviour for such pulses is not checked.

## Configuration
- `REQ_ENC_RR_EN` defined: round-robin selection replaces fixed priority.
  - A 2-bit pointer `last` resets to 2'b11.
  - The search order is `last`+1, `last`+2, … (mod 4), and the first pending index in that order wins.
  - `last` updates to the granted index on each load.
  - The first grant after reset therefore favours index 0.
- `REQ_ENC_RR_EN` undefined: fixed highest-index priority. No pointer logic is synthesised.

## Test plan
- **Single request:** after reset, with `out_ready`=1, raise `req`=4'b0100 → `out_valid` high 3 edges later with `out_code`=2'b10 for 1 cycle; `pending` returns to 4'b0000.
- **Simultaneous requests:** raise `req`=4'b1011 in one cycle, `out_ready`=1 →
  - fixed priority: codes 11, 01, 00 on consecutive cycles;
  - with `REQ_ENC_RR_EN`: codes 00, 01, 11.
- **Backpressure:** with `out_ready`=0, raise `req`=4'b0001 then 4'b0011 →
  - `out_code`=00 is held with `out_valid`=1 and `pending`=4'b0010;
  - raise `out_ready` → 01 follows on the next cycle, then `out_valid` drops.
- **Overrun:**
  - hold `out_ready`=0 and pulse `req[2]` twice, 4 cycles apart → `overrun`=4'b0100, `pending[2]`=1;
  - pulse `ovr_clr` → `overrun`=4'b0000.
- **Reset mid-operation:** assert `rst_n`=0 while `out_valid`=1 and `pending`=4'b1010 → all outputs take their reset values immediately, without waiting for a clock; with `req` held high through release, no code is emitted.
